// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the periodic timer sequencer.
// Holds FSM states, CPU and timer register addresses, CTRL bit indices.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLO,
        S_WHI,
        S_RUN,
        S_ACK
    } state_t;

    localparam logic [1:0] A_RLO  = 2'd0;
    localparam logic [1:0] A_RHI  = 2'd1;
    localparam logic [1:0] A_PCNT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IRQ  = 1;
    localparam int CTRL_BUSY = 2;

    localparam logic [1:0] T_LO   = 2'd0;
    localparam logic [1:0] T_HI   = 2'd1;
    localparam logic [1:0] T_STAT = 2'd2;

    // The timer never expires on 0, so 0 is armed as 1.
    function automatic logic [15:0] eff_reload(input logic [15:0] r);
        return (r == 16'h0000) ? 16'h0001 : r;
    endfunction

endpackage

// File: rtl/timer_sched.sv
// Periodic sequencer for the one-shot divisor timer; raises intr every PCNT periods.
// Ports: clk/rst_n; CPU slave AD/DI/DO/rw/cs; timer master t_AD/t_DO/t_rw/t_cs/t_intr; intr.
import timer_sched_pkg::*;

module timer_sched #(
    parameter logic [15:0] RELOAD_RST = 16'h0100,
    parameter logic [7:0]  PCNT_RST   = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic [1:0] t_AD,
    output logic [7:0] t_DO,
    output logic       t_rw,
    output logic       t_cs,
    input  logic       t_intr,
    output logic       intr
);

    state_t      state;
    state_t      state_nx;
    logic [15:0] reload;
    logic [15:0] reload_eff;
    logic [15:0] arm;
    logic [7:0]  pcnt;
    logic [7:0]  rem;
    logic        en;
    logic        irq;
    logic        from_run;
    logic        wr;
    logic        busy;
    logic        irq_set;

    logic [1:0]  t_ad_nx;
    logic [7:0]  t_do_nx;
    logic        t_rw_nx;
    logic        t_cs_nx;

    assign wr         = cs & ~rw;
    assign reload_eff = eff_reload(reload);
    assign busy       = (state == S_WLO) || (state == S_WHI) || (state == S_ACK);
    // rem==1 about to hit 0; rem==0 stands for 256 and just wraps to 255.
    assign irq_set    = (state == S_ACK) && from_run && (rem == 8'd1);
    assign intr       = irq;

    always_comb begin
        DO = 8'h00;
        unique case (AD)
            A_RLO:  DO = reload[7:0];
            A_RHI:  DO = reload[15:8];
            A_PCNT: DO = pcnt;
            A_CTRL: DO = {5'b0, busy, irq, en};
        endcase
    end

    // CPU-visible registers; an IRQ set beats a same-cycle CPU clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= RELOAD_RST;
            pcnt   <= PCNT_RST;
            en     <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr) begin
                unique case (AD)
                    A_RLO:  reload[7:0]  <= DI;
                    A_RHI:  reload[15:8] <= DI;
                    A_PCNT: pcnt         <= DI;
                    A_CTRL: begin
                        en <= DI[CTRL_EN];
                        if (DI[CTRL_IRQ]) irq <= 1'b0;
                    end
                endcase
            end
            if (irq_set) irq <= 1'b1;
        end
    end

    // Period counter; arm snapshots the reload so a CPU write mid-pair
    // cannot split the LO/HI bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= 8'h00;
            arm      <= 16'h0000;
            from_run <= 1'b0;
        end else begin
            if (state == S_IDLE && en)
                rem <= pcnt;
            else if (irq_set)
                rem <= pcnt;
            else if (state == S_ACK && from_run)
                rem <= rem - 8'd1;
            // ACK is only entered from RUN or IDLE.
            from_run <= (state == S_RUN);
            if (state_nx == S_WLO) arm <= reload_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (en)          state_nx = S_WLO;
                else if (t_intr) state_nx = S_ACK;
            end
            S_WLO: state_nx = S_WHI;
            S_WHI: state_nx = S_RUN;
            S_RUN: begin
                if (!en)         state_nx = S_IDLE;
                else if (t_intr) state_nx = S_ACK;
            end
            S_ACK: state_nx = (en && from_run) ? S_WLO : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so
    // each access is one clean cycle aligned with its state.
    always_comb begin
        t_cs_nx = 1'b0;
        t_rw_nx = 1'b1;
        t_ad_nx = T_LO;
        t_do_nx = 8'h00;
        unique case (state_nx)
            S_WLO: begin
                t_cs_nx = 1'b1;
                t_rw_nx = 1'b0;
                t_ad_nx = T_LO;
                t_do_nx = reload_eff[7:0];
            end
            S_WHI: begin
                t_cs_nx = 1'b1;
                t_rw_nx = 1'b0;
                t_ad_nx = T_HI;
                t_do_nx = arm[15:8];
            end
            S_ACK: begin
                t_cs_nx = 1'b1;
                t_ad_nx = T_STAT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cs <= 1'b0;
            t_rw <= 1'b1;
            t_AD <= T_LO;
            t_DO <= 8'h00;
        end else begin
            t_cs <= t_cs_nx;
            t_rw <= t_rw_nx;
            t_AD <= t_ad_nx;
            t_DO <= t_do_nx;
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched with a behavioural one-shot timer.
// Expected timer accesses and intr rises are queued with their cycle stamps.
import timer_sched_pkg::*;

module tb_timer_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic [1:0] t_AD;
    logic [7:0] t_DO;
    logic       t_rw;
    logic       t_cs;
    logic       t_intr;
    logic       intr;

    timer_sched dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .AD     (AD),
        .DI     (DI),
        .DO     (DO),
        .rw     (rw),
        .cs     (cs),
        .t_AD   (t_AD),
        .t_DO   (t_DO),
        .t_rw   (t_rw),
        .t_cs   (t_cs),
        .t_intr (t_intr),
        .intr   (intr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-shot divisor timer: HI write loads {hi,lo} and starts it,
    // flag stays up until a read of address 2.
    logic [7:0]  tm_lo   = 8'h00;
    logic [15:0] tm_cnt  = 16'h0000;
    logic        tm_run  = 1'b0;
    logic        tm_flag = 1'b0;

    always @(posedge clk) begin
        if (t_cs && !t_rw && t_AD == T_LO) tm_lo <= t_DO;
        if (t_cs && !t_rw && t_AD == T_HI) begin
            tm_cnt <= {t_DO, tm_lo};
            tm_run <= 1'b1;
        end else if (tm_run && tm_cnt == 16'd1) begin
            tm_flag <= 1'b1;
            tm_run  <= 1'b0;
        end else if (tm_run && tm_cnt != 16'd0) begin
            tm_cnt <= tm_cnt - 16'd1;
        end
        if (t_cs && t_rw && t_AD == T_STAT) tm_flag <= 1'b0;
    end
    assign t_intr = tm_flag;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] sbq[$];
    logic        irq_m = 1'b0;
    logic        intr_q = 1'b0;

    function automatic logic [63:0] ev(input bit k, input int c,
                                       input logic r, input logic [1:0] a,
                                       input logic [7:0] d);
        return {20'b0, k, c, r, a, d};
    endfunction

    task automatic sb_cmp(input string tag, input logic [63:0] obs);
        if (sbq.size() == 0) chk({tag, "_unexp"}, obs, {64{1'b1}});
        else                 chk(tag, obs, sbq.pop_front());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (t_cs)
                sb_cmp("bus", ev(1'b0, cyc, t_rw, t_AD,
                                 t_rw ? 8'h00 : t_DO));
            if (intr && !intr_q)
                sb_cmp("intr", ev(1'b1, cyc, 1'b0, 2'd0, 8'h00));
        end
        intr_q <= intr;
    end

    // Queue the access pattern for a run enabled at edge c.
    task automatic plan(input int c, input logic [15:0] rl, input int pc,
                        input int nper, input int clr_k);
        logic [15:0] re;
        int p;
        int rm;
        int t;
        re = (rl == 16'h0000) ? 16'h0001 : rl;
        p  = int'(re) + 4;
        rm = (pc == 0) ? 256 : pc;
        sbq.push_back(ev(1'b0, c + 1, 1'b0, T_LO, re[7:0]));
        sbq.push_back(ev(1'b0, c + 2, 1'b0, T_HI, re[15:8]));
        for (int k = 0; k < nper; k++) begin
            t = c + 4 + int'(re) + k * p;
            sbq.push_back(ev(1'b0, t, 1'b1, T_STAT, 8'h00));
            sbq.push_back(ev(1'b0, t + 1, 1'b0, T_LO, re[7:0]));
            rm--;
            if (rm == 0) begin
                rm = (pc == 0) ? 256 : pc;
                if (!irq_m) sbq.push_back(ev(1'b1, t + 1, 1'b0, 2'd0, 8'h00));
                irq_m = 1'b1;
            end
            sbq.push_back(ev(1'b0, t + 2, 1'b0, T_HI, re[15:8]));
            if (k == clr_k) irq_m = 1'b0;
        end
    endtask

    function automatic int whi_t(input int c, input int re, input int k);
        return c + 6 + re + k * (re + 4);
    endfunction

    int wr_cyc;

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Call at a negedge; commits on the next posedge.
    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        AD = a;
        DI = d;
        rw = 1'b0;
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        rw = 1'b1;
        wr_cyc = cyc;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        AD = a;
        rw = 1'b1;
        cs = 1'b0;
        #1;
        d = DO;
    endtask

    // Disable after the WHI at cycle l; the running timer's flag must
    // then be cleared by exactly one ACK from IDLE.
    task automatic stop_at(input int l, input int re, input logic [7:0] ctrl);
        logic [7:0] d;
        wait_cyc(l);
        cpu_wr(A_CTRL, ctrl);
        if (ctrl[1]) irq_m = 1'b0;
        chk("stop_intr", intr, irq_m);
        sbq.push_back(ev(1'b0, l + 2 + re, 1'b1, T_STAT, 8'h00));
        wait_cyc(l + re + 5);
        chk("stop_drain", sbq.size(), 0);
        cpu_rd(A_CTRL, d);
        chk("stop_ctrl", d, {6'b0, irq_m, 1'b0});
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int c;
        rst_n = 1'b0;
        AD = 2'd0;
        DI = 8'h00;
        rw = 1'b1;
        cs = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_t_cs", t_cs, 1'b0);
        chk("rst_t_rw", t_rw, 1'b1);
        chk("rst_intr", intr, 1'b0);
        cpu_rd(A_RLO, d);  chk("rst_rlo", d, 8'h00);
        cpu_rd(A_RHI, d);  chk("rst_rhi", d, 8'h01);
        cpu_rd(A_PCNT, d); chk("rst_pcnt", d, 8'h01);
        cpu_rd(A_CTRL, d); chk("rst_ctrl", d, 8'h00);
        @(negedge clk);

        // reload 16, one intr per period
        cpu_wr(A_RLO, 8'h10);
        cpu_wr(A_RHI, 8'h00);
        cpu_wr(A_PCNT, 8'h01);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0010, 1, 2, 0);
        wait_cyc(whi_t(c, 16, 0));
        cpu_wr(A_CTRL, 8'h03);
        chk("b_clr_intr", intr, 1'b0);
        stop_at(whi_t(c, 16, 1), 16, 8'h02);

        // reload 8, intr every 3 expiries
        cpu_wr(A_RLO, 8'h08);
        cpu_wr(A_PCNT, 8'h03);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0008, 3, 6, 3);
        wait_cyc(whi_t(c, 8, 3));
        cpu_wr(A_CTRL, 8'h03);
        chk("c_clr_intr", intr, 1'b0);
        stop_at(whi_t(c, 8, 5), 8, 8'h00);

        // PCNT=0 means 256 expiries per intr
        cpu_wr(A_CTRL, 8'h02);
        irq_m = 1'b0;
        cpu_wr(A_RLO, 8'h01);
        cpu_wr(A_PCNT, 8'h00);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0001, 0, 257, -1);
        stop_at(whi_t(c, 1, 256), 1, 8'h00);

        // reload 0 armed as 1
        cpu_wr(A_RLO, 8'h00);
        cpu_wr(A_PCNT, 8'h01);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0000, 1, 2, -1);
        stop_at(whi_t(c, 1, 1), 1, 8'h00);

        // EN cleared during WLO: WHI still issued
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0000, 1, 0, -1);
        wait_cyc(c + 1);
        cpu_wr(A_CTRL, 8'h00);
        sbq.push_back(ev(1'b0, c + 5, 1'b1, T_STAT, 8'h00));
        wait_cyc(c + 8);
        chk("f_drain", sbq.size(), 0);
        cpu_rd(A_CTRL, d);
        chk("f_ctrl", d, 8'h02);
        @(negedge clk);

        // IRQ clear in the same cycle as the set
        cpu_wr(A_CTRL, 8'h02);
        irq_m = 1'b0;
        cpu_wr(A_RLO, 8'h08);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0008, 1, 1, -1);
        wait_cyc(c + 12);
        cpu_wr(A_CTRL, 8'h03);
        chk("g_race_intr", intr, 1'b1);
        cpu_rd(A_CTRL, d);
        chk("g_race_ctrl", d, 8'h07);
        @(negedge clk);
        stop_at(c + 14, 8, 8'h00);

        // reset asserted during WHI
        cpu_wr(A_RHI, 8'h00);
        cpu_wr(A_CTRL, 8'h01);
        c = wr_cyc;
        plan(c, 16'h0008, 1, 0, -1);
        wait_cyc(c + 2);
        #2 rst_n = 1'b0;
        #1;
        chk("h_t_cs", t_cs, 1'b0);
        chk("h_t_rw", t_rw, 1'b1);
        chk("h_t_ad", t_AD, 2'd0);
        chk("h_t_do", t_DO, 8'h00);
        chk("h_intr", intr, 1'b0);
        cpu_rd(A_RLO, d);  chk("h_rlo", d, 8'h00);
        cpu_rd(A_RHI, d);  chk("h_rhi", d, 8'h01);
        cpu_rd(A_PCNT, d); chk("h_pcnt", d, 8'h01);
        cpu_rd(A_CTRL, d); chk("h_ctrl", d, 8'h00);
        rst_n = 1'b1;
        irq_m = 1'b0;
        @(negedge clk);
        repeat (30) @(negedge clk);
        chk("h_drain", sbq.size(), 0);
        chk("h_tm_run", tm_run, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
